// File: rtl/vga_line_fetch.sv
// Scanline prefetcher for the 1-bpp display: fills ping-pong line buffers over a
// 32-bit read bus and serves registered byte reads from the front buffer.
module vga_line_fetch #(
  parameter int C_bytes_per_line = 80,
  parameter int C_lines          = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] frame_base,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [15:0] dispAddr,
  output logic [7:0]  dispData,
  output logic        bus_strobe,
  output logic [29:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_data,
  output logic        fetch_busy,
  output logic        underrun
);

  localparam int          WORDS       = C_bytes_per_line / 4;
  localparam int          WA          = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] LINE_BYTES  = 32'(C_bytes_per_line);
  localparam logic [31:0] FRAME_BYTES = 32'(C_bytes_per_line * C_lines);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [31:0]   buf0 [WORDS];
  logic [31:0]   buf1 [WORDS];

  logic          hsync_p1, vsync_p1;
  logic          front_sel, first, complete;
  logic [15:0]   line_base;
  logic [1:0]    state;
  logic [WA-1:0] w;
  logic          tgt_sel;
  logic          pend, pend_sel;
  logic [29:0]   pend_addr;

  logic          hs_rise, vs_rise, swap, start_req, start_sel;
  logic [31:0]   base_byte, nxt_byte, start_byte;
  logic          ack, last, wr_en;
  logic [15:0]   rd_idx;
  logic [WA-1:0] rd_widx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [3:0]    unused_bits;

  assign bus_strobe  = (state == S_REQ);
  assign fetch_busy  = (state == S_REQ);
  assign unused_bits = {frame_base[1:0], start_byte[1:0]};

  // A vsync edge overrides a coincident hsync edge; the start target is the
  // buffer that will be "back" after this cycle's swap (if any).
  always_comb begin
    hs_rise    = vga_hsync & ~hsync_p1;
    vs_rise    = vga_vsync & ~vsync_p1;
    swap       = hs_rise & ~vs_rise & (first | (dispAddr != line_base));
    base_byte  = {frame_base[31:2], 2'b00};
    nxt_byte   = {16'd0, dispAddr} + LINE_BYTES;
    start_req  = 1'b0;
    start_byte = base_byte;
    start_sel  = ~front_sel;
    if (vs_rise) begin
      start_req = enable;
    end else if (swap) begin
      start_req  = enable && (nxt_byte < FRAME_BYTES);
      start_byte = base_byte + nxt_byte;
      start_sel  = front_sel;
    end
    ack   = (state == S_REQ) & bus_ack;
    last  = (w == WA'(WORDS - 1));
    wr_en = ack & ~pend & ~start_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      front_sel <= 1'b0;
      line_base <= 16'd0;
      first     <= 1'b1;
      complete  <= 1'b0;
      underrun  <= 1'b0;
      state     <= S_IDLE;
      w         <= '0;
      bus_addr  <= 30'd0;
      tgt_sel   <= 1'b1;
      pend      <= 1'b0;
      pend_sel  <= 1'b0;
      pend_addr <= 30'd0;
    end else begin
      hsync_p1 <= vga_hsync;
      vsync_p1 <= vga_vsync;

      if (vs_rise) begin
        first     <= 1'b1;
        line_base <= 16'd0;
      end else if (swap) begin
        front_sel <= ~front_sel;
        line_base <= dispAddr;
        first     <= 1'b0;
        if ((state == S_REQ) || !complete)
          underrun <= 1'b1;
      end

      if (start_req)
        complete <= 1'b0;
      else if (wr_en && last)
        complete <= 1'b1;

      // The strobe is never withdrawn mid-word: a restart during REQ waits for
      // the ack, discards that word and reissues on the next cycle.
      case (state)
        S_REQ: begin
          if (start_req) begin
            if (bus_ack) begin
              w        <= '0;
              bus_addr <= start_byte[31:2];
              tgt_sel  <= start_sel;
              pend     <= 1'b0;
            end else begin
              pend      <= 1'b1;
              pend_addr <= start_byte[31:2];
              pend_sel  <= start_sel;
            end
          end else if (bus_ack) begin
            if (pend) begin
              w        <= '0;
              bus_addr <= pend_addr;
              tgt_sel  <= pend_sel;
              pend     <= 1'b0;
            end else begin
              w        <= w + 1'b1;
              bus_addr <= bus_addr + 30'd1;
              if (last)
                state <= S_DONE;
            end
          end
        end
        default: begin
          if (start_req) begin
            state    <= S_REQ;
            w        <= '0;
            bus_addr <= start_byte[31:2];
            tgt_sel  <= start_sel;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Line buffer write stage
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (tgt_sel)
        buf1[w] <= bus_data;
      else
        buf0[w] <= bus_data;
    end
  end

  always_comb begin
    rd_idx  = dispAddr - line_base;
    rd_widx = rd_idx[WA+1:2];
    rd_word = front_sel ? buf1[rd_widx] : buf0[rd_widx];
    rd_byte = rd_word[{rd_idx[1:0], 3'b000} +: 8];
  end

  // Display read stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dispData <= 8'd0;
    else
      dispData <= (enable && ({16'd0, rd_idx} < LINE_BYTES)) ? rd_byte : 8'd0;
  end

endmodule
